// File: rtl/hazard_unit.sv
// Stall and operand-forwarding control for a five-stage pipeline, built on E/M/W destination records.
// Define HAZARD_FWD_EN to build the forwarding network; without it every RAW dependence stalls until the producer leaves M.
module hazard_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] rs_d,
   input  logic [4:0] rt_d,
   input  logic [1:0] tuse_rs_d,
   input  logic [1:0] tuse_rt_d,
   input  logic [4:0] A3_D,
   input  logic       WE_D,
   input  logic [1:0] tnew_d,
   output logic       stall,
   output logic       en_pc,
   output logic       en_fd,
   output logic       flush_e,
   output logic [1:0] fwd_rs_d,
   output logic [1:0] fwd_rt_d,
   output logic [1:0] fwd_rs_e,
   output logic [1:0] fwd_rt_e,
   output logic       fwd_rt_m
);
   localparam logic [1:0] TUSE_NONE = 2'd3;

   logic [4:0] a3_e_r;
   logic [4:0] rs_e_r;
   logic [4:0] rt_e_r;
   logic       we_e_r;
   logic [1:0] tnew_e_r;
   logic [4:0] a3_m_r;
   logic [4:0] rt_m_r;
   logic       we_m_r;
   logic [1:0] tnew_m_r;
   logic [4:0] a3_w_r;
   logic       we_w_r;
   logic [1:0] tnew_w_r;

   logic       rs_used_s;
   logic       rt_used_s;
   logic       rs_hit_e_s;
   logic       rs_hit_m_s;
   logic       rt_hit_e_s;
   logic       rt_hit_m_s;
   logic       stall_s;
   logic [1:0] tnew_dec_s;
   logic       unused_s;

   function automatic logic producer_match(input logic we, input logic [4:0] a3, input logic [4:0] src);
      return we && (a3 == src) && (src != 5'd0);
   endfunction

   assign tnew_dec_s = (tnew_e_r == 2'd0) ? 2'd0 : (tnew_e_r - 2'd1);

   // Record shift: a stall holds F/D and bubbles E while M and W keep draining
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a3_e_r   <= 5'd0;
         rs_e_r   <= 5'd0;
         rt_e_r   <= 5'd0;
         we_e_r   <= 1'b0;
         tnew_e_r <= 2'd0;
         a3_m_r   <= 5'd0;
         rt_m_r   <= 5'd0;
         we_m_r   <= 1'b0;
         tnew_m_r <= 2'd0;
         a3_w_r   <= 5'd0;
         we_w_r   <= 1'b0;
         tnew_w_r <= 2'd0;
      end else begin
         a3_w_r   <= a3_m_r;
         we_w_r   <= we_m_r;
         tnew_w_r <= tnew_m_r;
         a3_m_r   <= a3_e_r;
         rt_m_r   <= rt_e_r;
         we_m_r   <= we_e_r;
         tnew_m_r <= tnew_dec_s;
         if (stall_s) begin
            a3_e_r   <= 5'd0;
            rs_e_r   <= 5'd0;
            rt_e_r   <= 5'd0;
            we_e_r   <= 1'b0;
            tnew_e_r <= 2'd0;
         end else begin
            a3_e_r   <= A3_D;
            rs_e_r   <= rs_d;
            rt_e_r   <= rt_d;
            we_e_r   <= WE_D;
            tnew_e_r <= tnew_d;
         end
      end
   end

   assign rs_used_s  = (tuse_rs_d != TUSE_NONE);
   assign rt_used_s  = (tuse_rt_d != TUSE_NONE);
   assign rs_hit_e_s = producer_match(we_e_r, a3_e_r, rs_d);
   assign rs_hit_m_s = producer_match(we_m_r, a3_m_r, rs_d);
   assign rt_hit_e_s = producer_match(we_e_r, a3_e_r, rt_d);
   assign rt_hit_m_s = producer_match(we_m_r, a3_m_r, rt_d);

`ifdef HAZARD_FWD_EN
   function automatic logic [1:0] sel_d(input logic hit_e, input logic [1:0] tn_e,
                                        input logic hit_m, input logic [1:0] tn_m);
      if (hit_e && (tn_e == 2'd0)) begin
         return 2'b01;
      end else if (hit_m && (tn_m == 2'd0)) begin
         return 2'b10;
      end else begin
         return 2'b00;
      end
   endfunction

   function automatic logic [1:0] sel_e(input logic hit_m, input logic [1:0] tn_m, input logic hit_w);
      if (hit_m && (tn_m == 2'd0)) begin
         return 2'b01;
      end else if (hit_w) begin
         return 2'b10;
      end else begin
         return 2'b00;
      end
   endfunction

   // A source stalls only while its producer's result lands later than the stage that consumes it
   assign stall_s = (rs_used_s && ((rs_hit_e_s && (tnew_e_r > tuse_rs_d)) ||
                                   (rs_hit_m_s && (tnew_m_r > tuse_rs_d)))) ||
                    (rt_used_s && ((rt_hit_e_s && (tnew_e_r > tuse_rt_d)) ||
                                   (rt_hit_m_s && (tnew_m_r > tuse_rt_d))));

   assign fwd_rs_d = sel_d(rs_hit_e_s, tnew_e_r, rs_hit_m_s, tnew_m_r);
   assign fwd_rt_d = sel_d(rt_hit_e_s, tnew_e_r, rt_hit_m_s, tnew_m_r);
   assign fwd_rs_e = sel_e(producer_match(we_m_r, a3_m_r, rs_e_r), tnew_m_r,
                           producer_match(we_w_r, a3_w_r, rs_e_r));
   assign fwd_rt_e = sel_e(producer_match(we_m_r, a3_m_r, rt_e_r), tnew_m_r,
                           producer_match(we_w_r, a3_w_r, rt_e_r));
   assign fwd_rt_m = producer_match(we_w_r, a3_w_r, rt_m_r);

   // W results are always complete, so the W countdown is carried but never consulted
   assign unused_s = ^tnew_w_r;
`else
   assign stall_s = (rs_used_s && (rs_hit_e_s || rs_hit_m_s)) ||
                    (rt_used_s && (rt_hit_e_s || rt_hit_m_s));

   assign fwd_rs_d = 2'b00;
   assign fwd_rt_d = 2'b00;
   assign fwd_rs_e = 2'b00;
   assign fwd_rt_e = 2'b00;
   assign fwd_rt_m = 1'b0;

   assign unused_s = ^{rs_e_r, rt_e_r, rt_m_r, tnew_m_r, tnew_w_r, a3_w_r, we_w_r};
`endif

   assign stall   = stall_s;
   assign en_pc   = ~stall_s;
   assign en_fd   = ~stall_s;
   assign flush_e = stall_s;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed pipeline scenarios plus randomized traffic against a cycle-timestamp model.
module tb_hazard_unit;
`ifdef HAZARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs_d, rt_d, A3_D;
   logic [1:0] tuse_rs_d, tuse_rt_d, tnew_d;
   logic       WE_D;
   logic       stall, en_pc, en_fd, flush_e, fwd_rt_m;
   logic [1:0] fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   hazard_unit dut (
      .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d),
      .tuse_rs_d(tuse_rs_d), .tuse_rt_d(tuse_rt_d), .A3_D(A3_D), .WE_D(WE_D), .tnew_d(tnew_d),
      .stall(stall), .en_pc(en_pc), .en_fd(en_fd), .flush_e(flush_e),
      .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e),
      .fwd_rt_m(fwd_rt_m)
   );

   // Model: each instruction remembers the absolute cycle at which its result becomes forwardable
   typedef struct {
      logic [4:0] a3;
      logic       we;
      int         ready;
      logic [4:0] rs;
      logic [4:0] rt;
   } rec_t;

   rec_t pipe[$];   // [0]=E, [1]=M, [2]=W
   int   cyc;

   function automatic rec_t bubble_rec();
      rec_t b;
      b.a3 = 5'd0; b.we = 1'b0; b.ready = 0; b.rs = 5'd0; b.rt = 5'd0;
      return b;
   endfunction

   function automatic logic hit(rec_t p, logic [4:0] s);
      return p.we && (p.a3 == s) && (s != 5'd0);
   endfunction

   task automatic model_reset();
      pipe.delete();
      for (int k = 0; k < 3; k++) pipe.push_back(bubble_rec());
      cyc = 0;
   endtask

   task automatic model_advance(input logic stl);
      rec_t n;
      cyc++;
      if (stl) n = bubble_rec();
      else begin
         n.a3 = A3_D; n.we = WE_D; n.ready = cyc + int'(tnew_d); n.rs = rs_d; n.rt = rt_d;
      end
      pipe.push_front(n);
      void'(pipe.pop_back());
   endtask

   // Operand is needed at cycle cyc+tuse; stall while any in-flight producer is ready later than that
   function automatic logic need_stall(logic [4:0] s, logic [1:0] u);
      if (u == 2'd3) return 1'b0;
      for (int k = 0; k < 2; k++)
         if (hit(pipe[k], s) && (!FWD || (pipe[k].ready > cyc + int'(u)))) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [1:0] d_sel(logic [4:0] s);
      if (!FWD) return 2'b00;
      if (hit(pipe[0], s) && pipe[0].ready <= cyc) return 2'b01;
      if (hit(pipe[1], s) && pipe[1].ready <= cyc) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [1:0] e_sel(logic [4:0] s);
      if (!FWD) return 2'b00;
      if (hit(pipe[1], s) && pipe[1].ready <= cyc) return 2'b01;
      if (hit(pipe[2], s)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic logic [12:0] model_expect();
      logic stl;
      logic fm;
      stl = need_stall(rs_d, tuse_rs_d) || need_stall(rt_d, tuse_rt_d);
      fm  = FWD && hit(pipe[2], pipe[1].rt);
      return {stl, ~stl, ~stl, stl, d_sel(rs_d), d_sel(rt_d), e_sel(pipe[0].rs), e_sel(pipe[0].rt), fm};
   endfunction

   function automatic logic [12:0] outs();
      return {stall, en_pc, en_fd, flush_e, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m};
   endfunction

   task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] urs,
                        input logic [1:0] urt, input logic [4:0] a3, input logic we, input logic [1:0] tn);
      rs_d = rs; rt_d = rt; tuse_rs_d = urs; tuse_rt_d = urt; A3_D = a3; WE_D = we; tnew_d = tn;
   endtask

   task automatic set_nop();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b0, 2'd0);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      set_nop();
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic count_stall(output int n);
      n = 0;
      while (stall === 1'b1 && n < 8) begin
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_nop();
      #1;
      checks++;
      if (outs() !== 13'h0C00) begin
         errors++; $display("FAIL reset_idle got %h want %h", outs(), 13'h0C00);
      end
      set_d(5'd1, 5'd2, 2'd0, 2'd0, 5'd1, 1'b1, 2'd2);
      #1;
      checks++;
      if (outs() !== 13'h0C00) begin
         errors++; $display("FAIL reset_dinputs got %h want %h", outs(), 13'h0C00);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_load_use();
      int n;
      do_reset();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 1'b1, 2'd2);
      @(negedge clk);
      set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 1'b1, 2'd1);
      #1;
      checks++;
      if ({stall, flush_e, en_pc, en_fd} !== 4'b1100) begin
         errors++; $display("FAIL load_use_flags got %b want %b", {stall, flush_e, en_pc, en_fd}, 4'b1100);
      end
      count_stall(n);
      checks++;
      if (n != (FWD ? 1 : 2)) begin
         errors++; $display("FAIL load_use_stall_cycles got %0d want %0d", n, FWD ? 1 : 2);
      end
      @(negedge clk);
      set_nop();
      #1;
      checks++;
      if (fwd_rs_e !== (FWD ? 2'b10 : 2'b00)) begin
         errors++; $display("FAIL load_use_fwd_rs_e got %b want %b", fwd_rs_e, FWD ? 2'b10 : 2'b00);
      end
   endtask

   task automatic test_branch();
      int n;
      do_reset();
      set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 1'b1, 2'd1);
      @(negedge clk);
      set_d(5'd3, 5'd0, 2'd0, 2'd3, 5'd0, 1'b0, 2'd0);
      #1;
      count_stall(n);
      checks++;
      if (n != (FWD ? 1 : 2)) begin
         errors++; $display("FAIL branch_stall_cycles got %0d want %0d", n, FWD ? 1 : 2);
      end
      checks++;
      if ({fwd_rs_d, fwd_rt_d} !== {(FWD ? 2'b10 : 2'b00), 2'b00}) begin
         errors++; $display("FAIL branch_fwd_d got %b want %b", {fwd_rs_d, fwd_rt_d}, {(FWD ? 2'b10 : 2'b00), 2'b00});
      end
   endtask

   task automatic test_store();
      int n;
      do_reset();
      set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd5, 1'b1, 2'd1);
      @(negedge clk);
      set_d(5'd0, 5'd5, 2'd1, 2'd2, 5'd0, 1'b0, 2'd0);
      #1;
      count_stall(n);
      checks++;
      if (n != (FWD ? 0 : 2)) begin
         errors++; $display("FAIL store_stall_cycles got %0d want %0d", n, FWD ? 0 : 2);
      end
      @(negedge clk);
      set_nop();
      #1;
      checks++;
      if (fwd_rt_e !== (FWD ? 2'b01 : 2'b00)) begin
         errors++; $display("FAIL store_fwd_rt_e got %b want %b", fwd_rt_e, FWD ? 2'b01 : 2'b00);
      end
      @(negedge clk);
      #1;
      checks++;
      if (fwd_rt_m !== FWD) begin
         errors++; $display("FAIL store_fwd_rt_m got %b want %b", fwd_rt_m, FWD);
      end
   endtask

   task automatic test_r0();
      do_reset();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 1'b1, 2'd1);
      @(negedge clk);
      set_d(5'd0, 5'd0, 2'd0, 2'd0, 5'd7, 1'b1, 2'd1);
      #1;
      checks++;
      if ({stall, fwd_rs_d, fwd_rt_d} !== 5'b0) begin
         errors++; $display("FAIL r0_d got %b want %b", {stall, fwd_rs_d, fwd_rt_d}, 5'b0);
      end
      @(negedge clk);
      set_nop();
      #1;
      checks++;
      if ({fwd_rs_e, fwd_rt_e} !== 4'b0) begin
         errors++; $display("FAIL r0_e got %b want %b", {fwd_rs_e, fwd_rt_e}, 4'b0);
      end
   endtask

   task automatic test_alu_dep();
      int n;
      do_reset();
      set_d(5'd1, 5'd2, 2'd1, 2'd1, 5'd4, 1'b1, 2'd1);
      @(negedge clk);
      set_d(5'd4, 5'd0, 2'd1, 2'd3, 5'd6, 1'b1, 2'd1);
      #1;
      count_stall(n);
      checks++;
      if (n != (FWD ? 0 : 2)) begin
         errors++; $display("FAIL alu_dep_stall_cycles got %0d want %0d", n, FWD ? 0 : 2);
      end
      @(negedge clk);
      set_nop();
      #1;
      checks++;
      if (fwd_rs_e !== (FWD ? 2'b01 : 2'b00)) begin
         errors++; $display("FAIL alu_dep_fwd_rs_e got %b want %b", fwd_rs_e, FWD ? 2'b01 : 2'b00);
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 5'd8, 1'b1, 2'd2);
      @(negedge clk);
      set_d(5'd8, 5'd0, 2'd1, 2'd3, 5'd9, 1'b1, 2'd1);
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++; $display("FAIL mid_stall_pre got %b want %b", stall, 1'b1);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (outs() !== 13'h0C00) begin
         errors++; $display("FAIL mid_stall_async got %h want %h", outs(), 13'h0C00);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL mid_stall_records got %b want %b", stall, 1'b0);
      end
   endtask

   function automatic logic [4:0] rnd_reg();
      return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
   endfunction

   task automatic test_random();
      logic        held;
      logic [12:0] exp_v;
      do_reset();
      model_reset();
      held = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         if (!held)
            set_d(rnd_reg(), rnd_reg(), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  rnd_reg(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)));
         #1;
         exp_v = model_expect();
         checks++;
         if (outs() !== exp_v) begin
            errors++; $display("FAIL random_cycle_%0d got %h want %h", i, outs(), exp_v);
         end
         held = exp_v[12];
         if ($urandom_range(0, 63) == 0) begin
            rst = 1'b0;
            #1;
            checks++;
            if (outs() !== 13'h0C00) begin
               errors++; $display("FAIL random_async_reset got %h want %h", outs(), 13'h0C00);
            end
            @(negedge clk);
            rst = 1'b1;
            model_reset();
            held = 1'b0;
         end else begin
            @(posedge clk);
            model_advance(exp_v[12]);
            @(negedge clk);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch();
      test_store();
      test_r0();
      test_alu_dep();
      test_reset_mid_stall();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  in  1  pipeline clock, all state on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 rs_d / rt_d  in  5 each  D-stage source register numbers.
REQ-004 tuse_rs_d / tuse_rt_d  in  2 each  cycles until operand needed: 0=D (branch compare), 1=E (ALU), 2=M (store data), 3=unused.
REQ-005 A3_D  in  5  D-stage destination register.
REQ-006 WE_D  in  1  D-stage instruction writes A3_D.
REQ-007 tnew_d  in  2  cycles after entering E until result is forwardable: 0=jal/lui, 1=ALU, 2=load.
REQ-008 stall  out  1  hazard detected this cycle.
REQ-009 en_pc / en_fd  out  1 each  PC and F/D register enables; equal to ~stall.
REQ-010 flush_e  out  1  load bubble into D/E register; equal to stall.
REQ-011 fwd_rs_d / fwd_rt_d  out  2 each  D operand source: 00 regfile, 01 E result, 10 M result.
REQ-012 fwd_rs_e / fwd_rt_e  out  2 each  E operand source: 00 pipeline reg, 01 M result, 10 W result.
REQ-013 fwd_rt_m  out  1  M store data source: 0 pipeline reg, 1 W result.

Function
REQ-014 Internal records E, M, W each hold {a3, we, tnew}; E additionally holds rs_e, rt_e; M holds rt_m.
REQ-015 Each clk edge: W<=M, M<=E with tnew=max(tnew_e-1,0), E<={A3_D,WE_D,tnew_d,rs_d,rt_d} or bubble when stall=1.
REQ-016 Bubble: a3=0, we=0, tnew=0, rs=0, rt=0.
REQ-017 Producer match for source s: record.we=1, record.a3==s, s!=0; register 0 never matches.
REQ-018 stall=1 iff any used source (tuse!=3) matches E with tnew_e>tuse, or matches M with tnew_m>tuse.
REQ-019 D forwarding: match E with tnew_e==0 -> 01; else match M with tnew_m==0 -> 10; else 00; E priority over M.
REQ-020 E forwarding on rs_e/rt_e: match M with tnew_m==0 -> 01; else match W -> 10; else 00.
REQ-021 fwd_rt_m=1 iff rt_m matches W.
REQ-022 Stall holds F and D; M and W continue draining; stall self-clears once producer tnew drops to <=tuse.
REQ-023 All outputs combinational from records and D inputs; zero added latency.
REQ-024 Regfile write-through covers W-to-D; no W forwarding to D.

Reset
REQ-025 rst low: all records cleared to bubble immediately, independent of clk.
REQ-026 During and after reset, before any edge: stall=0, en_pc=1, en_fd=1, flush_e=0, all fwd selects 0.
REQ-027 Reset mid-stall drops stall on the same asynchronous assertion.

Configuration
REQ-028 Macro HAZARD_FWD_EN defined: forwarding per REQ-019..021.
REQ-029 Macro absent: all fwd outputs tied 0; stall iff any used source matches E or M regardless of tnew; records retained.

Verification
REQ-030 lw r8 (tnew 2) then add r9,r8 (tuse_rs 1) -> stall=1 one cycle, flush_e=1; next cycle fwd_rs_e=10.
REQ-031 addu r3 (tnew 1) then beq r3 (tuse 0) -> stall 1 cycle; then fwd_rs_d=10.
REQ-032 addu r5 then sw rt=r5 (tuse_rt 2) -> no stall; fwd_rt_e=01 in E.
REQ-033 WE_D=1, A3_D=0, next instr rs_d=0 -> stall=0, all fwd=00.
REQ-034 Assert rst low while stall=1 -> stall=0, en_pc=1 without clk edge; records bubble.
REQ-035 HAZARD_FWD_EN undefined, addu r4 then or r6,r4 -> stall 2 cycles, fwd_rs_e stays 00.
